// File: rtl/iq_cov_acc_pkg.sv
// Shared definitions for the I/Q covariance accumulator.
//   npair()      : number of upper-triangle elements for a channel count
//   pair_index() : row-major upper-triangle position of element (i,j), j >= i
//   cov_elem_t   : {im, re} element layout for the default configuration
//                  (NCH=4, DW=16, LOG2_LEN=10); re sits in the low half
//   PIPE_DEPTH   : cycles from snapshot acceptance to output valid
package iq_cov_pkg;

    localparam int PIPE_DEPTH = 4;
    localparam int DEF_OW     = 2 * 16 + 1 + 10;

    typedef struct packed {
        logic signed [DEF_OW-1:0] im;
        logic signed [DEF_OW-1:0] re;
    } cov_elem_t;

    function automatic int npair(input int nch);
        return (nch * (nch + 1)) / 2;
    endfunction

    // Row i starts after rows 0..i-1, which hold nch, nch-1, ... elements.
    function automatic int pair_index(input int nch, input int i, input int j);
        return i * nch - (i * (i - 1)) / 2 + (j - i);
    endfunction

endpackage

// File: rtl/iq_cov_acc_if.sv
// Stream bundle between the per-channel DDC outputs, the covariance
// accumulator and the DOA processor.
//   axis_di/axis_dq : packed per-channel I/Q samples, ch k at [k*DW +: DW]
//   axis_vi/axis_vq : per-channel valids
//   axis_ri/axis_rq : per-channel readies (all bits identical)
//   axis_do0        : upper-triangle covariance word, element p at [p*2*OW +: 2*OW]
//   axis_vo0/ro0    : output valid / ready
// master = sample source + result sink, slave = accumulator.
interface iq_cov_acc_if
    import iq_cov_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DW       = 16,
    parameter int LOG2_LEN = 10
);
    localparam int NPAIR = npair(NCH);
    localparam int OW    = 2 * DW + 1 + LOG2_LEN;

    logic [NCH*DW-1:0]       axis_di;
    logic [NCH-1:0]          axis_vi;
    logic [NCH*DW-1:0]       axis_dq;
    logic [NCH-1:0]          axis_vq;
    logic [NCH-1:0]          axis_ri;
    logic [NCH-1:0]          axis_rq;
    logic [NPAIR*2*OW-1:0]   axis_do0;
    logic                    axis_vo0;
    logic                    axis_ro0;

    modport master (
        output axis_di, axis_vi, axis_dq, axis_vq, axis_ro0,
        input  axis_ri, axis_rq, axis_do0, axis_vo0
    );

    modport slave (
        input  axis_di, axis_vi, axis_dq, axis_vq, axis_ro0,
        output axis_ri, axis_rq, axis_do0, axis_vo0
    );

endinterface

// File: rtl/iq_cov_acc_cmac.sv
// One covariance lane: x_i * conj(x_j) followed by frame accumulation.
//   S1 : four DW x DW products
//   S2 : Re = Ii*Ij + Qi*Qj, Im = Qi*Ij - Ii*Qj (2*DW+1 bits, exact)
//   S3 : accumulate; the first snapshot of a frame loads instead of adding
// Ports: aclk/areset, per-stage valids (s0_v, s1_v, s2_v), s2_first frame
// start tag, channel samples ii/qi/ij/qj, accumulator outputs acc_re/acc_im.
module iq_cmac #(
    parameter int DW = 16,
    parameter int OW = 43
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s0_v,
    input  logic                 s1_v,
    input  logic                 s2_v,
    input  logic                 s2_first,
    input  logic signed [DW-1:0] ii,
    input  logic signed [DW-1:0] qi,
    input  logic signed [DW-1:0] ij,
    input  logic signed [DW-1:0] qj,
    output logic signed [OW-1:0] acc_re,
    output logic signed [OW-1:0] acc_im
);
    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;

    logic signed [PW-1:0] p_ii_r, p_qq_r, p_qi_r, p_iq_r;
    logic signed [SW-1:0] re_r, im_r;
    logic signed [OW-1:0] acc_re_r, acc_im_r;

    // S1: partial products of the conjugate multiply
    always_ff @(posedge aclk) begin
        if (areset) begin
            p_ii_r <= '0;
            p_qq_r <= '0;
            p_qi_r <= '0;
            p_iq_r <= '0;
        end else if (s0_v) begin
            p_ii_r <= PW'(ii) * PW'(ij);
            p_qq_r <= PW'(qi) * PW'(qj);
            p_qi_r <= PW'(qi) * PW'(ij);
            p_iq_r <= PW'(ii) * PW'(qj);
        end
    end

    // S2: combine partial products into the complex product
    always_ff @(posedge aclk) begin
        if (areset) begin
            re_r <= '0;
            im_r <= '0;
        end else if (s1_v) begin
            re_r <= SW'(p_ii_r) + SW'(p_qq_r);
            im_r <= SW'(p_qi_r) - SW'(p_iq_r);
        end
    end

    // S3: frame accumulator, width chosen so a full frame cannot overflow
    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_re_r <= '0;
            acc_im_r <= '0;
        end else if (s2_v) begin
            if (s2_first) begin
                acc_re_r <= OW'(re_r);
                acc_im_r <= OW'(im_r);
            end else begin
                acc_re_r <= acc_re_r + OW'(re_r);
                acc_im_r <= acc_im_r + OW'(im_r);
            end
        end
    end

    assign acc_re = acc_re_r;
    assign acc_im = acc_im_r;

endmodule

// File: rtl/iq_cov_acc.sv
// Hermitian sample covariance R = sum x*x^H over NCH channels, 2^LOG2_LEN
// snapshots per frame, upper triangle emitted as one wide word.
// Ports: aclk, areset (synchronous, active-high), bus (slave side of
// iq_cov_acc_if: per-channel I/Q samples in, covariance word out).
// This module owns the input handshake, snapshot counter, first/last tags
// and output register; the NPAIR iq_cmac lanes do the arithmetic.
module iq_cov_acc
    import iq_cov_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DW       = 16,
    parameter int LOG2_LEN = 10,
    parameter int AVG      = 0
) (
    input  logic         aclk,
    input  logic         areset,
    iq_cov_acc_if.slave  bus
);
    localparam int NPAIR = npair(NCH);
    localparam int OW    = 2 * DW + 1 + LOG2_LEN;
    localparam int WW    = NPAIR * 2 * OW;
    localparam logic [LOG2_LEN-1:0] CNT_LAST = '1;

    logic                accept_s;
    logic                ready_r, ready_nxt_s;
    logic [LOG2_LEN-1:0] cnt_r, cnt_nxt_s;
    logic                inflight_nxt_s;
    logic                vo0_r, vo0_nxt_s;
    logic [WW-1:0]       do_r, out_word_s;

    logic                s0_v_r, s0_first_r, s0_last_r;
    logic [NCH*DW-1:0]   s0_di_r, s0_dq_r;
    logic                s1_v_r, s1_first_r, s1_last_r;
    logic                s2_v_r, s2_first_r, s2_last_r;
    logic                s3_last_r;

    // Next-state view of handshake state; ready is registered from it so
    // it tracks the counter and output state without a cycle of slip.
    always_comb begin
        accept_s = ready_r & (&bus.axis_vi) & (&bus.axis_vq);
        if (accept_s) begin
            cnt_nxt_s = cnt_r + LOG2_LEN'(1'b1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        // Tags in S0..S2 now are the ones in S1..S3 after this edge.
        inflight_nxt_s = (s0_v_r & s0_last_r) | (s1_v_r & s1_last_r) | (s2_v_r & s2_last_r);
        if (s3_last_r) begin
            vo0_nxt_s = 1'b1;
        end else if (vo0_r & bus.axis_ro0) begin
            vo0_nxt_s = 1'b0;
        end else begin
            vo0_nxt_s = vo0_r;
        end
        // Hold off a frame's last snapshot until the previous result is
        // gone and no other last snapshot is still travelling.
        ready_nxt_s = !((cnt_nxt_s == CNT_LAST) && (vo0_nxt_s || inflight_nxt_s));
    end

    // Counter, ready, S0 input register and tag pipeline S1..S3
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_r      <= '0;
            ready_r    <= 1'b0;
            s0_v_r     <= 1'b0;
            s0_first_r <= 1'b0;
            s0_last_r  <= 1'b0;
            s0_di_r    <= '0;
            s0_dq_r    <= '0;
            s1_v_r     <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s2_v_r     <= 1'b0;
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s3_last_r  <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            ready_r    <= ready_nxt_s;
            s0_v_r     <= accept_s;
            s0_first_r <= (cnt_r == '0);
            s0_last_r  <= (cnt_r == CNT_LAST);
            if (accept_s) begin
                s0_di_r <= bus.axis_di;
                s0_dq_r <= bus.axis_dq;
            end
            s1_v_r     <= s0_v_r;
            s1_first_r <= s0_first_r;
            s1_last_r  <= s0_last_r;
            s2_v_r     <= s1_v_r;
            s2_first_r <= s1_first_r;
            s2_last_r  <= s1_last_r;
            s3_last_r  <= s2_v_r & s2_last_r;
        end
    end

    // Output register: loads when the last snapshot leaves S3, clears on handshake
    always_ff @(posedge aclk) begin
        if (areset) begin
            vo0_r <= 1'b0;
            do_r  <= '0;
        end else begin
            vo0_r <= vo0_nxt_s;
            if (s3_last_r) begin
                do_r <= out_word_s;
            end else if (vo0_r & bus.axis_ro0) begin
                do_r <= '0;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_row
        for (genvar gj = gi; gj < NCH; gj++) begin : g_col
            localparam int P = pair_index(NCH, gi, gj);
            logic signed [OW-1:0] acc_re_s, acc_im_s;

            iq_cmac #(
                .DW (DW),
                .OW (OW)
            ) u_cmac (
                .aclk     (aclk),
                .areset   (areset),
                .s0_v     (s0_v_r),
                .s1_v     (s1_v_r),
                .s2_v     (s2_v_r),
                .s2_first (s2_first_r),
                .ii       (s0_di_r[gi*DW +: DW]),
                .qi       (s0_dq_r[gi*DW +: DW]),
                .ij       (s0_di_r[gj*DW +: DW]),
                .qj       (s0_dq_r[gj*DW +: DW]),
                .acc_re   (acc_re_s),
                .acc_im   (acc_im_s)
            );

            if (AVG != 0) begin : g_avg
                assign out_word_s[P*2*OW +: OW]      = acc_re_s >>> LOG2_LEN;
                assign out_word_s[P*2*OW + OW +: OW] = acc_im_s >>> LOG2_LEN;
            end else begin : g_raw
                assign out_word_s[P*2*OW +: OW]      = acc_re_s;
                assign out_word_s[P*2*OW + OW +: OW] = acc_im_s;
            end
        end
    end

    assign bus.axis_ri  = {NCH{ready_r}};
    assign bus.axis_rq  = {NCH{ready_r}};
    assign bus.axis_do0 = do_r;
    assign bus.axis_vo0 = vo0_r;

endmodule

// File: tb/tb_iq_cov_acc.sv
// Self-checking bench for iq_cov_acc (NCH=4, DW=16, LOG2_LEN=2).
// A frame table drives constant-snapshot frames and checks selected
// elements; an independent covariance model feeds a scoreboard queue that
// is compared whenever the DUT hands over a word. Hand-written sequences
// cover backpressure, partial valids and mid-frame reset. A second instance
// with AVG=1 shares the inputs and is checked on the first frame.
module tb_iq_cov_acc;
    import iq_cov_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int L2  = 2;
    localparam int LEN = 1 << L2;
    localparam int OW  = 2 * DW + 1 + L2;
    localparam int NP  = NCH * (NCH + 1) / 2;
    localparam int WW  = NP * 2 * OW;

    typedef logic [NCH-1:0][DW-1:0] chv_t;
    typedef struct {
        chv_t   ci;
        chv_t   cq;
        longint r00_re;
        longint r01_re;
        longint r01_im;
        longint r12_re;
        longint r33_re;
    } vec_t;

    logic aclk = 1'b0;
    logic areset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   acc_total = 0;

    vec_t   vecs [5];
    longint m_re [NP];
    longint m_im [NP];
    int     m_cnt = 0;
    logic [WW-1:0] exp_q [$];

    iq_cov_acc_if #(.NCH(NCH), .DW(DW), .LOG2_LEN(L2)) bus0 ();
    iq_cov_acc_if #(.NCH(NCH), .DW(DW), .LOG2_LEN(L2)) bus1 ();

    iq_cov_acc #(.NCH(NCH), .DW(DW), .LOG2_LEN(L2), .AVG(0)) u_dut0 (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus0)
    );

    iq_cov_acc #(.NCH(NCH), .DW(DW), .LOG2_LEN(L2), .AVG(1)) u_dut1 (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus1)
    );

    assign bus1.axis_di  = bus0.axis_di;
    assign bus1.axis_dq  = bus0.axis_dq;
    assign bus1.axis_vi  = bus0.axis_vi;
    assign bus1.axis_vq  = bus0.axis_vq;
    assign bus1.axis_ro0 = 1'b1;

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic longint fld(input logic [WW-1:0] w, input int p, input bit im);
        logic signed [OW-1:0] v;
        v = w[p*2*OW + (im ? OW : 0) +: OW];
        return longint'(v);
    endfunction

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            m_re[p] = 0;
            m_im[p] = 0;
        end
        m_cnt = 0;
    endtask

    // Independent covariance model; pushes the expected word after each frame.
    task automatic model_accept(input chv_t ci, input chv_t cq);
        int p;
        logic [WW-1:0] w;
        longint a_i, a_q, b_i, b_q;
        p = 0;
        for (int i = 0; i < NCH; i++) begin
            for (int j = i; j < NCH; j++) begin
                a_i = longint'($signed(ci[i]));
                a_q = longint'($signed(cq[i]));
                b_i = longint'($signed(ci[j]));
                b_q = longint'($signed(cq[j]));
                m_re[p] += a_i * b_i + a_q * b_q;
                m_im[p] += a_q * b_i - a_i * b_q;
                p++;
            end
        end
        m_cnt++;
        acc_total++;
        if (m_cnt == LEN) begin
            w = '0;
            for (int k = 0; k < NP; k++) begin
                w[k*2*OW +: OW]      = m_re[k][OW-1:0];
                w[k*2*OW + OW +: OW] = m_im[k][OW-1:0];
            end
            exp_q.push_back(w);
            model_clear();
        end
    endtask

    // Offer n snapshots with valid held high; each accepted edge updates the model.
    task automatic send(input int n, input chv_t ci, input chv_t cq);
        int  got;
        int  guard;
        logic rdy;
        got = 0;
        guard = 0;
        @(negedge aclk);
        bus0.axis_di = ci;
        bus0.axis_dq = cq;
        bus0.axis_vi = '1;
        bus0.axis_vq = '1;
        while (got < n && guard < 300) begin
            rdy = bus0.axis_ri[0] & bus0.axis_rq[0];
            @(posedge aclk);
            #1;
            if (rdy) begin
                got++;
                last_acc_cyc = cyc;
                model_accept(ci, cq);
            end
            @(negedge aclk);
            guard++;
        end
        bus0.axis_vi = '0;
        bus0.axis_vq = '0;
        chk("send_accepts", got, n);
    endtask

    task automatic wait_vo(output int lat);
        int k;
        k = 0;
        lat = -1;
        while (k < 40) begin
            @(posedge aclk);
            #1;
            if (bus0.axis_vo0) begin
                lat = cyc - last_acc_cyc;
                break;
            end
            k++;
        end
        chk("vo0_latency", lat, PIPE_DEPTH);
    endtask

    // Scoreboard: compare the handed-over word against the model's queue.
    always @(negedge aclk) begin
        #2;
        if (!areset && bus0.axis_vo0 && bus0.axis_ro0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_word actual=%h", bus0.axis_do0);
            end else begin
                logic [WW-1:0] e;
                e = exp_q.pop_front();
                if (bus0.axis_do0 !== e) begin
                    errors++;
                    $display("FAIL sb_word actual=%h expected=%h", bus0.axis_do0, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input int v, input int k, input int i, input int q);
        vecs[v].ci[k] = DW'(i);
        vecs[v].cq[k] = DW'(q);
    endtask

    task automatic set_exp(input int v, input longint a, input longint b, input longint c,
                           input longint d, input longint e);
        vecs[v].r00_re = a;
        vecs[v].r01_re = b;
        vecs[v].r01_im = c;
        vecs[v].r12_re = d;
        vecs[v].r33_re = e;
    endtask

    initial begin
        int lat;
        bit ok_r, ok_v;
        logic [WW-1:0] hold_w;

        areset = 1'b1;
        bus0.axis_di = '0;
        bus0.axis_dq = '0;
        bus0.axis_vi = '0;
        bus0.axis_vq = '0;
        bus0.axis_ro0 = 1'b1;
        model_clear();

        // Frame table: every snapshot of a frame identical.
        for (int k = 0; k < NCH; k++) set_ch(0, k, 1, 0);
        set_exp(0, 4, 4, 0, 4, 4);
        set_ch(1, 0, 0, 1);
        for (int k = 1; k < NCH; k++) set_ch(1, k, 1, 0);
        set_exp(1, 4, 0, 4, 4, 4);
        for (int k = 0; k < NCH; k++) set_ch(2, k, -32768, -32768);
        set_exp(2, 64'sd8589934592, 64'sd8589934592, 0, 64'sd8589934592, 64'sd8589934592);
        set_ch(3, 0, 3, -2);
        set_ch(3, 1, -5, 7);
        set_ch(3, 2, 100, 200);
        set_ch(3, 3, -1, -1);
        set_exp(3, 52, -116, -44, 3600, 8);
        set_ch(4, 0, 32767, -32768);
        set_ch(4, 1, -32768, 32767);
        set_ch(4, 2, 0, 0);
        set_ch(4, 3, 0, 0);
        set_exp(4, 64'sd8589672452, -64'sd8589672448, 262140, 0, 0);

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_vo0", longint'(bus0.axis_vo0), 0);
        chk("rst_do0_zero", longint'(bus0.axis_do0 == '0), 1);
        chk("rst_ready", longint'({bus0.axis_rq, bus0.axis_ri}), 0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("ready_after_rst", longint'({bus0.axis_rq, bus0.axis_ri}), 255);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            send(LEN, vecs[v].ci, vecs[v].cq);
            wait_vo(lat);
            chk($sformatf("v%0d_r00_re", v), fld(bus0.axis_do0, 0, 1'b0), vecs[v].r00_re);
            chk($sformatf("v%0d_r00_im", v), fld(bus0.axis_do0, 0, 1'b1), 0);
            chk($sformatf("v%0d_r01_re", v), fld(bus0.axis_do0, 1, 1'b0), vecs[v].r01_re);
            chk($sformatf("v%0d_r01_im", v), fld(bus0.axis_do0, 1, 1'b1), vecs[v].r01_im);
            chk($sformatf("v%0d_r12_re", v), fld(bus0.axis_do0, 5, 1'b0), vecs[v].r12_re);
            chk($sformatf("v%0d_r33_re", v), fld(bus0.axis_do0, 9, 1'b0), vecs[v].r33_re);
            if (v == 0) begin
                chk("avg_vo0", longint'(bus1.axis_vo0), 1);
                chk("avg_r00_re", fld(bus1.axis_do0, 0, 1'b0), 1);
                chk("avg_r23_re", fld(bus1.axis_do0, 8, 1'b0), 1);
                chk("avg_r01_im", fld(bus1.axis_do0, 1, 1'b1), 0);
            end
        end

        // Backpressure: output stalled while valid stays high
        repeat (3) @(negedge aclk);
        acc_total = 0;
        bus0.axis_ro0 = 1'b0;
        fork
            send(2 * LEN, vecs[3].ci, vecs[3].cq);
            begin
                repeat (20) @(negedge aclk);
                #2;
                chk("bp_ready_low", longint'(bus0.axis_ri[0]), 0);
                chk("bp_vo0_held", longint'(bus0.axis_vo0), 1);
                chk("bp_accepts", acc_total, 2 * LEN - 1);
                chk("bp_r01_re", fld(bus0.axis_do0, 1, 1'b0), -116);
                hold_w = bus0.axis_do0;
                @(negedge aclk);
                #2;
                chk("bp_word_stable", longint'(bus0.axis_do0 == hold_w), 1);
                @(posedge aclk);
                #1;
                bus0.axis_ro0 = 1'b1;
                @(posedge aclk);
                #1;
                chk("bp_vo0_cleared", longint'(bus0.axis_vo0), 0);
                chk("bp_ready_back", longint'(bus0.axis_ri[0]), 1);
            end
        join
        wait_vo(lat);
        chk("bp_f2_r01_im", fld(bus0.axis_do0, 1, 1'b1), -44);

        // Partial valids consume nothing
        @(negedge aclk);
        bus0.axis_di = vecs[0].ci;
        bus0.axis_dq = vecs[0].cq;
        bus0.axis_vi = 4'b0111;
        bus0.axis_vq = 4'b0111;
        ok_r = 1'b1;
        ok_v = 1'b1;
        repeat (10) begin
            @(posedge aclk);
            #1;
            if (!bus0.axis_ri[0]) ok_r = 1'b0;
            if (bus0.axis_vo0) ok_v = 1'b0;
        end
        chk("partial_ready_high", longint'(ok_r), 1);
        chk("partial_no_vo0", longint'(ok_v), 1);
        @(negedge aclk);
        bus0.axis_vi = '0;
        bus0.axis_vq = '0;
        send(LEN, vecs[1].ci, vecs[1].cq);
        wait_vo(lat);
        chk("partial_r01_im", fld(bus0.axis_do0, 1, 1'b1), 4);

        // Reset mid-frame with an unread word pending
        repeat (3) @(negedge aclk);
        bus0.axis_ro0 = 1'b0;
        send(LEN + 2, vecs[3].ci, vecs[3].cq);
        repeat (4) @(negedge aclk);
        chk("pre_rst_vo0", longint'(bus0.axis_vo0), 1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        chk("mid_rst_vo0", longint'(bus0.axis_vo0), 0);
        chk("mid_rst_ready", longint'(bus0.axis_ri[0]), 0);
        exp_q.delete();
        model_clear();
        @(negedge aclk);
        areset = 1'b0;
        bus0.axis_ro0 = 1'b1;
        send(LEN, vecs[0].ci, vecs[0].cq);
        wait_vo(lat);
        chk("post_rst_r00_re", fld(bus0.axis_do0, 0, 1'b0), 4);
        chk("post_rst_r12_re", fld(bus0.axis_do0, 5, 1'b0), 4);

        repeat (4) @(negedge aclk);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
